// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: definitions shared by the RAM controller and the RAM wrapper.
//   RAM_ADDR_W / RAM_DATA_W : default geometry of the 32x4 single-port RAM.
//   state_t                 : controller FSM states.
package ram_ctrl_pkg;

    localparam int unsigned RAM_ADDR_W = 5;
    localparam int unsigned RAM_DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FETCH,
        CAPTURE,
        CLEAR
    } state_t;

endpackage

// File: rtl/scan_tick.sv
// scan_tick: terminal-count counter pacing the auto-scan.
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   enable        : advance the count by one per cycle
//   clear         : force the count back to 0 (highest priority)
//   accept        : consumer has taken the pending tick; count returns to 0
//   pending       : count sits at SCAN_TICKS-1 and holds there until accepted
module scan_tick #(
    parameter int unsigned SCAN_TICKS = 50000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    input  logic accept,
    output logic pending
);

    localparam int unsigned CNT_W = $clog2(SCAN_TICKS);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(SCAN_TICKS - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear || accept) begin
            cnt <= '0;
        end else if (enable && (cnt != TERM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign pending = (cnt == TERM);

endmodule

// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: owns the address/data/write-enable inputs of a single-port
// RAM and arbitrates single-word writes, a full clear sweep and a periodic
// auto-scan read. Every completed write or read is latched for display.
//   clock, resetn          : rising-edge clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data : write request (rising edge) with its address/data
//   clr_req                : clear request (rising edge)
//   scan_en                : level enable for the auto-scan
//   ram_addr/data/wren     : combinational drive into the RAM
//   ram_q                  : RAM read data (valid the cycle after addressing)
//   disp_addr/disp_data    : last captured address/word
//   busy                   : controller is not IDLE
module ram_scan_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = RAM_ADDR_W,
    parameter int unsigned DATA_W     = RAM_DATA_W,
    parameter int unsigned SCAN_TICKS = 50000000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] op_addr, clr_cnt, scan_addr, scan_next;
    logic [DATA_W-1:0] op_data;
    logic              wr_q, clr_q;
    logic              wr_rise, clr_rise;
    logic              tick_pending, tick_accept;

    // Edge registers reset high so a request held through reset is ignored.
    assign wr_rise   = wr_req & ~wr_q;
    assign clr_rise  = clr_req & ~clr_q;
    assign scan_next = scan_addr + 1'b1;

    scan_tick #(
        .SCAN_TICKS(SCAN_TICKS)
    ) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .enable ((state_q == IDLE) && scan_en),
        .clear  (~scan_en),
        .accept (tick_accept),
        .pending(tick_pending)
    );

    always_comb begin
        state_d     = state_q;
        ram_addr    = op_addr;
        ram_data    = '0;
        ram_wren    = 1'b0;
        tick_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_rise) begin
                    state_d = CLEAR;
                end else if (wr_rise) begin
                    state_d = WRITE;
                end else if (tick_pending) begin
                    state_d     = FETCH;
                    tick_accept = 1'b1;
                end
            end
            WRITE: begin
                ram_wren = 1'b1;
                ram_data = op_data;
                state_d  = CAPTURE;
            end
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            CLEAR: begin
                ram_wren = 1'b1;
                ram_addr = clr_cnt;
                if (clr_cnt == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            op_addr   <= '0;
            op_data   <= '0;
            clr_cnt   <= '0;
            scan_addr <= '0;
            disp_addr <= '0;
            disp_data <= '0;
            wr_q      <= 1'b1;
            clr_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_req;
            clr_q   <= clr_req;
            case (state_q)
                IDLE: begin
                    if (clr_rise) begin
                        clr_cnt <= '0;
                    end else if (wr_rise) begin
                        op_addr <= wr_addr;
                        op_data <= wr_data;
                    end else if (tick_pending) begin
                        scan_addr <= scan_next;
                        op_addr   <= scan_next;
                    end
                end
                CAPTURE: begin
                    disp_data <= ram_q;
                    disp_addr <= op_addr;
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        scan_addr <= '0;
                        op_addr   <= '0;
                        disp_addr <= '0;
                        disp_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// tb_ram_scan_ctrl: directed bench for ram_scan_ctrl driving a behavioural
// 32x4 single-port RAM (registered address, new data on read-during-write).
module tb_ram_scan_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       wr_req, clr_req, scan_en;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] ram_addr, disp_addr;
    logic [3:0] ram_data, ram_q, disp_data;
    logic       ram_wren, busy;

    always #5 clock = ~clock;

    ram_scan_ctrl #(
        .ADDR_W    (5),
        .DATA_W    (4),
        .SCAN_TICKS(4)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .scan_en  (scan_en),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q),
        .disp_addr(disp_addr),
        .disp_data(disp_data),
        .busy     (busy)
    );

    // Behavioural RAM.
    logic [3:0] mem [32];
    logic [4:0] addr_r;
    always @(posedge clock) begin
        addr_r <= ram_addr;
        if (ram_wren) mem[ram_addr] <= ram_data;
    end
    assign ram_q = mem[addr_r];

    // Write-enable log and busy-cycle counter, sampled mid-cycle.
    logic [4:0] log_addr [$];
    logic [3:0] log_data [$];
    int unsigned busy_cnt;
    always @(negedge clock) begin
        if (ram_wren) begin
            log_addr.push_back(ram_addr);
            log_data.push_back(ram_data);
        end
        if (busy) busy_cnt++;
    end

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] d);
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        @(negedge clock);
        wr_req = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic fill_all(input logic [3:0] d);
        for (int i = 0; i < 32; i++) do_write(5'(i), d);
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        @(negedge clock);
        clr_req = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned bound, output bit ok);
        int unsigned n = 0;
        while (busy && n < bound) begin
            @(negedge clock);
            n++;
        end
        ok = !busy;
    endtask

    task automatic scan_step(output bit ok);
        int unsigned n = 0;
        while (!busy && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (!busy) begin
            ok = 1'b0;
        end else begin
            wait_idle(10, ok);
        end
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        busy_cnt = 0;
    endtask

    function automatic int unsigned count_val(input int unsigned lo, input int unsigned hi,
                                              input logic [3:0] v);
        int unsigned c = 0;
        for (int i = lo; i <= int'(hi); i++) if (mem[i] === v) c++;
        return c;
    endfunction

    initial begin
        bit          ok, all_ok;
        int unsigned errs;
        logic [4:0]  exp_a;

        resetn  = 1'b0;
        wr_req  = 1'b1;
        clr_req = 1'b0;
        scan_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        busy_cnt = 0;
        repeat (3) @(negedge clock);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wren", ram_wren, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_disp_addr", disp_addr, 0);
        check_eq("rst_disp_data", disp_data, 0);

        // wr_req held through reset release must not start a write.
        clear_logs();
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        check_eq("held_wr_busy", busy_cnt, 0);
        check_eq("held_wr_wren", log_addr.size(), 0);
        wr_req = 1'b0;
        repeat (2) @(negedge clock);

        // Single write: addr 5, data 9.
        clear_logs();
        wr_addr = 5'd5;
        wr_data = 4'd9;
        wr_req  = 1'b1;
        @(negedge clock);
        wr_req = 1'b0;
        check_eq("wr_wren", ram_wren, 1);
        check_eq("wr_addr", ram_addr, 5);
        check_eq("wr_data", ram_data, 9);
        @(negedge clock);
        check_eq("wr_capture_wren", ram_wren, 0);
        @(negedge clock);
        check_eq("wr_disp_addr", disp_addr, 5);
        check_eq("wr_disp_data", disp_data, 9);
        check_eq("wr_busy", busy, 0);
        @(negedge clock);
        check_eq("wr_busy_cycles", busy_cnt, 2);
        check_eq("wr_wren_cycles", log_addr.size(), 1);

        // Auto-scan with wrap.
        do_write(5'd0, 4'd3);
        do_write(5'd1, 4'd7);
        scan_en = 1'b1;
        scan_step(ok);
        check_eq("scan1_done", ok, 1);
        check_eq("scan1_addr", disp_addr, 1);
        check_eq("scan1_data", disp_data, 7);
        all_ok = 1'b1;
        for (int i = 0; i < 31; i++) begin
            scan_step(ok);
            all_ok &= ok;
        end
        check_eq("scan_wrap_done", all_ok, 1);
        check_eq("scan_wrap_addr", disp_addr, 0);
        check_eq("scan_wrap_data", disp_data, 3);
        scan_en = 1'b0;
        repeat (2) @(negedge clock);

        // Full clear over a 0xF-filled RAM.
        fill_all(4'hF);
        clear_logs();
        pulse_clr();
        wait_idle(40, ok);
        check_eq("clr_done", ok, 1);
        repeat (2) @(negedge clock);
        check_eq("clr_busy_cycles", busy_cnt, 32);
        check_eq("clr_wren_cycles", log_addr.size(), 32);
        errs = 0;
        for (int i = 0; i < 32 && i < int'(log_addr.size()); i++)
            if (log_addr[i] !== 5'(i) || log_data[i] !== 4'd0) errs++;
        check_eq("clr_sweep_order", errs, 0);
        check_eq("clr_disp_addr", disp_addr, 0);
        check_eq("clr_disp_data", disp_data, 0);
        check_eq("clr_mem_zero", count_val(0, 31, 4'd0), 32);
        scan_en = 1'b1;
        errs = 0;
        all_ok = 1'b1;
        exp_a = 5'd0;
        for (int i = 0; i < 32; i++) begin
            scan_step(ok);
            all_ok &= ok;
            exp_a = exp_a + 5'd1;
            if (disp_addr !== exp_a || disp_data !== 4'd0) errs++;
        end
        check_eq("clr_readback_done", all_ok, 1);
        check_eq("clr_readback_errs", errs, 0);
        scan_en = 1'b0;
        repeat (2) @(negedge clock);

        // Clear and write rising together: clear wins, write dropped.
        do_write(5'd4, 4'hA);
        clear_logs();
        wr_addr = 5'd7;
        wr_data = 4'd5;
        wr_req  = 1'b1;
        clr_req = 1'b1;
        @(negedge clock);
        wr_req  = 1'b0;
        clr_req = 1'b0;
        wait_idle(40, ok);
        repeat (5) @(negedge clock);
        check_eq("both_done", ok, 1);
        check_eq("both_wren_cycles", log_addr.size(), 32);
        check_eq("both_mem_zero", count_val(0, 31, 4'd0), 32);

        // Write edge during CLEAR is dropped.
        clear_logs();
        pulse_clr();
        repeat (5) @(negedge clock);
        wr_addr = 5'd3;
        wr_data = 4'd6;
        wr_req  = 1'b1;
        @(negedge clock);
        wr_req = 1'b0;
        wait_idle(40, ok);
        repeat (6) @(negedge clock);
        check_eq("busy_wr_done", ok, 1);
        check_eq("busy_wr_wren_cycles", log_addr.size(), 32);
        check_eq("busy_wr_mem3", mem[3], 0);

        // Reset on cycle 10 of CLEAR.
        fill_all(4'hF);
        pulse_clr();
        begin
            int unsigned n = 0;
            while (!(busy && ram_addr == 5'd10) && n < 40) begin
                @(negedge clock);
                n++;
            end
        end
        check_eq("mid_rst_reached", ram_addr, 10);
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_wren", ram_wren, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ram_addr", ram_addr, 0);
        check_eq("mid_rst_disp_addr", disp_addr, 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        clear_logs();
        repeat (6) @(negedge clock);
        check_eq("mid_rst_not_resumed", busy_cnt, 0);
        check_eq("mid_rst_low_zero", count_val(0, 9, 4'd0), 10);
        check_eq("mid_rst_high_kept", count_val(10, 31, 4'hF), 22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
